// File: rtl/shifter_output_rx_pkg.sv
// shifter_link_pkg: shared framing constants and receiver state for the shifter error-count link
package shifter_link_pkg;
  localparam int CHAIN_W    = 12;
  localparam int N_CHAINS   = 4;
  localparam int FRAME_BITS = CHAIN_W * N_CHAINS;
  localparam int FCNT_W     = 16;
  localparam int POS_W      = $clog2(CHAIN_W);
  localparam int BCNT_W     = $clog2(FRAME_BITS);
  typedef enum logic {HUNT = 1'b0, RECV = 1'b1} rx_state_t;
endpackage

// File: rtl/shifter_output_rx_if.sv
// shifter_output_rx_if: serial link input and reconstructed error-count outputs
interface shifter_output_rx_if;
  import shifter_link_pkg::*;
  logic              DATA_IN;
  logic              FRAME_SYNC;
  logic [CHAIN_W-1:0] RX_ERROR_0_0;
  logic [CHAIN_W-1:0] RX_ERROR_0_1;
  logic [CHAIN_W-1:0] RX_ERROR_1_0;
  logic [CHAIN_W-1:0] RX_ERROR_1_1;
  logic              FRAME_VALID;
  logic              SYNC_ERR;
  logic [FCNT_W-1:0] FRAME_COUNT;
  logic              LOCKED;
  modport master (output DATA_IN, FRAME_SYNC,
                  input RX_ERROR_0_0, RX_ERROR_0_1, RX_ERROR_1_0, RX_ERROR_1_1,
                  FRAME_VALID, SYNC_ERR, FRAME_COUNT, LOCKED);
  modport slave (input DATA_IN, FRAME_SYNC,
                 output RX_ERROR_0_0, RX_ERROR_0_1, RX_ERROR_1_0, RX_ERROR_1_1,
                 FRAME_VALID, SYNC_ERR, FRAME_COUNT, LOCKED);
endinterface

// File: rtl/shifter_output_rx_word.sv
// shifter_rx_word: LSB-first deserializer for one chain word with load-enable and clear
module shifter_rx_word
  import shifter_link_pkg::*;
(
  input  logic               DATA_CLK,
  input  logic               RST,
  input  logic               clr,
  input  logic               en,
  input  logic               d,
  input  logic [POS_W-1:0]   pos,
  output logic [CHAIN_W-1:0] nxt
);
  logic [CHAIN_W-1:0] q;
  // nxt already includes this cycle's bit so the top can latch a completed word directly
  always_comb begin
    nxt = clr ? '0 : q;
    if (en) nxt[pos] = d;
  end
  // hold the partial word
  always_ff @(posedge DATA_CLK) begin
    if (!RST) q <= '0;
    else q <= nxt;
  end
endmodule

// File: rtl/shifter_output_rx.sv
// shifter_output_rx: receive side of the shifter link, rebuilds four 12-bit chain error counts
module shifter_output_rx
  import shifter_link_pkg::*;
(
  input logic DATA_CLK,
  input logic RST,
  shifter_output_rx_if.slave link
);
  rx_state_t          state;
  logic [BCNT_W-1:0]  bit_cnt;
  logic [1:0]         chain;
  logic [POS_W-1:0]   pos;
  logic               start, mid_sync, recv, done;
  logic [CHAIN_W-1:0] word [N_CHAINS];
  logic [CHAIN_W-1:0] rx [N_CHAINS];
  logic [FCNT_W-1:0]  fcnt;
  logic               frame_valid, sync_err;
  // start covers both first alignment in HUNT and realignment on an unexpected sync
  always_comb begin
    chain    = 2'(bit_cnt / BCNT_W'(CHAIN_W));
    pos      = POS_W'(bit_cnt % BCNT_W'(CHAIN_W));
    start    = link.FRAME_SYNC && (state == HUNT || bit_cnt != '0);
    mid_sync = start && state == RECV;
    recv     = state == RECV && !start;
    done     = recv && bit_cnt == BCNT_W'(FRAME_BITS - 1);
  end
  for (genvar i = 0; i < N_CHAINS; i++) begin : g_word
    shifter_rx_word u_word (
      .DATA_CLK (DATA_CLK),
      .RST      (RST),
      .clr      (start),
      .en       (start ? i == 0 : recv && chain == 2'(i)),
      .d        (link.DATA_IN),
      .pos      (start ? '0 : pos),
      .nxt      (word[i])
    );
  end
  // alignment state and bit position within the frame
  always_ff @(posedge DATA_CLK) begin
    if (!RST) begin
      state   <= HUNT;
      bit_cnt <= '0;
    end else if (start) begin
      state   <= RECV;
      bit_cnt <= BCNT_W'(1);
    end else if (recv) begin
      bit_cnt <= done ? '0 : bit_cnt + 1'b1;
    end
  end
  // latch complete frames atomically and pulse the status flags
  always_ff @(posedge DATA_CLK) begin
    if (!RST) begin
      rx          <= '{default: '0};
      fcnt        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= done;
      sync_err    <= mid_sync;
      if (done) begin
        rx   <= word;
        fcnt <= fcnt + 1'b1;
      end
    end
  end
  assign link.RX_ERROR_0_0 = rx[0];
  assign link.RX_ERROR_0_1 = rx[1];
  assign link.RX_ERROR_1_0 = rx[2];
  assign link.RX_ERROR_1_1 = rx[3];
  assign link.FRAME_VALID  = frame_valid;
  assign link.SYNC_ERR     = sync_err;
  assign link.FRAME_COUNT  = fcnt;
  assign link.LOCKED       = state == RECV;
endmodule
